// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between the control unit and seq_alu.
// The master side issues start/opcode/operands; the slave side (the ALU)
// returns busy/done, the 2*WIDTH result and the sticky status flags.
`timescale 1ns/1ps

interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [4:0]         opcode;
    logic [WIDTH-1:0]   y;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] z;
    logic               div_zero;
    logic               illegal;

    modport master (
        output start, opcode, y, b,
        input  busy, done, z, div_zero, illegal
    );

    modport slave (
        input  start, opcode, y, b,
        output busy, done, z, div_zero, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU using the datapath opcode map (load=0 .. NOT=18).
// Single-cycle ops finish one cycle after accept; mul (radix-2 Booth) and
// div (non-restoring on magnitudes, sign-corrected) take WIDTH iterations.
// Optional feature macro: SEQ_ALU_DIV_EN enables the divider; without it,
// opcode div is treated as unmapped.
`timescale 1ns/1ps

module seq_alu #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      clr,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [4:0] {
        OP_LD   = 5'd0,
        OP_LDI  = 5'd1,
        OP_ST   = 5'd2,
        OP_ADD  = 5'd3,
        OP_SUB  = 5'd4,
        OP_AND  = 5'd5,
        OP_OR   = 5'd6,
        OP_SHR  = 5'd7,
        OP_SHRA = 5'd8,
        OP_SHL  = 5'd9,
        OP_ROR  = 5'd10,
        OP_ROL  = 5'd11,
        OP_ADDI = 5'd12,
        OP_ANDI = 5'd13,
        OP_ORI  = 5'd14,
        OP_MUL  = 5'd15,
        OP_DIV  = 5'd16,
        OP_NEG  = 5'd17,
        OP_NOT  = 5'd18
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_e;

    state_e             state;
    logic [SHW-1:0]     cnt;
    logic               busy_q;
    logic               done_q;
    logic               dz_q;
    logic               ill_q;
    logic [2*WIDTH-1:0] z_q;

    // Shared iteration registers: Booth uses acc/qreg/qm1 as {A, Q, q-1}
    // with mreg = multiplicand; the divider uses acc as the partial
    // remainder, qreg as dividend-shifting-into-quotient, mreg = |divisor|.
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   qreg;
    logic [WIDTH-1:0]   mreg;
    logic               qm1;

`ifdef SEQ_ALU_DIV_EN
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
`endif

    logic [SHW-1:0]     amt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ok;

    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     b_sum;
    logic [WIDTH:0]     b_acc_n;
    logic [WIDTH-1:0]   b_q_n;

    assign amt = bus.b[SHW-1:0];

    // Single-cycle result for the currently presented opcode/operands.
    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (bus.opcode)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: alu_res = bus.y + bus.b;
            OP_SUB:           alu_res = bus.y - bus.b;
            OP_AND, OP_ANDI:  alu_res = bus.y & bus.b;
            OP_OR, OP_ORI:    alu_res = bus.y | bus.b;
            OP_SHR:           alu_res = bus.y >> amt;
            OP_SHRA:          alu_res = $signed(bus.y) >>> amt;
            OP_SHL:           alu_res = bus.y << amt;
            OP_ROR:           alu_res = (bus.y >> amt) | (bus.y << (WIDTH - int'(amt)));
            OP_ROL:           alu_res = (bus.y << amt) | (bus.y >> (WIDTH - int'(amt)));
            OP_NEG:           alu_res = '0 - bus.b;
            OP_NOT:           alu_res = ~bus.b;
            default:          alu_ok  = 1'b0;
        endcase
    end

    // One Booth step: add/subtract multiplicand per {Q0, q-1}, then shift right arithmetically.
    always_comb begin
        m_ext = {mreg[WIDTH-1], mreg};
        case ({qreg[0], qm1})
            2'b01:   b_sum = acc + m_ext;
            2'b10:   b_sum = acc - m_ext;
            default: b_sum = acc;
        endcase
        b_acc_n = {b_sum[WIDTH], b_sum[WIDTH:1]};
        b_q_n   = {b_sum[0], qreg[WIDTH-1:1]};
    end

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]     d_shift;
    logic [WIDTH:0]     d_acc_n;
    logic [WIDTH-1:0]   d_q_n;
    logic [WIDTH-1:0]   d_rem_fix;
    logic [WIDTH-1:0]   d_quot;
    logic [WIDTH-1:0]   d_rem;

    // One non-restoring step, plus the final remainder fix-up and sign correction.
    always_comb begin
        d_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
        if (acc[WIDTH]) d_acc_n = d_shift + {1'b0, mreg};
        else            d_acc_n = d_shift - {1'b0, mreg};
        d_q_n     = {qreg[WIDTH-2:0], ~d_acc_n[WIDTH]};
        d_rem_fix = d_acc_n[WIDTH] ? d_acc_n[WIDTH-1:0] + mreg : d_acc_n[WIDTH-1:0];
        d_quot    = neg_q ? '0 - d_q_n : d_q_n;
        d_rem     = neg_r ? '0 - d_rem_fix : d_rem_fix;
    end
`endif

    // Control FSM with registered busy/done/flags/result and iteration datapath.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            ill_q  <= 1'b0;
            z_q    <= '0;
            acc    <= '0;
            qreg   <= '0;
            mreg   <= '0;
            qm1    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state == S_ITER) begin
                // Booth update by default; the divider step overrides it when active.
                acc  <= b_acc_n;
                qreg <= b_q_n;
                qm1  <= qreg[0];
`ifdef SEQ_ALU_DIV_EN
                if (is_div) begin
                    acc  <= d_acc_n;
                    qreg <= d_q_n;
                end
`endif
                if (cnt == '0) begin
                    state  <= S_DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    z_q    <= {b_acc_n[WIDTH-1:0], b_q_n};
`ifdef SEQ_ALU_DIV_EN
                    if (is_div) z_q <= {d_rem, d_quot};
`endif
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else begin
                // IDLE and DONE both accept, which gives back-to-back issue.
                state <= S_IDLE;
                if (bus.start) begin
                    dz_q  <= 1'b0;
                    ill_q <= 1'b0;
                    case (bus.opcode)
                        OP_MUL: begin
                            acc    <= '0;
                            qreg   <= bus.y;
                            mreg   <= bus.b;
                            qm1    <= 1'b0;
                            cnt    <= SHW'(WIDTH - 1);
                            busy_q <= 1'b1;
                            state  <= S_ITER;
`ifdef SEQ_ALU_DIV_EN
                            is_div <= 1'b0;
`endif
                        end
`ifdef SEQ_ALU_DIV_EN
                        OP_DIV: begin
                            if (bus.b == '0) begin
                                z_q    <= {bus.y, {WIDTH{1'b1}}};
                                dz_q   <= 1'b1;
                                done_q <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                acc    <= '0;
                                qreg   <= bus.y[WIDTH-1] ? '0 - bus.y : bus.y;
                                mreg   <= bus.b[WIDTH-1] ? '0 - bus.b : bus.b;
                                neg_q  <= bus.y[WIDTH-1] ^ bus.b[WIDTH-1];
                                neg_r  <= bus.y[WIDTH-1];
                                is_div <= 1'b1;
                                cnt    <= SHW'(WIDTH - 1);
                                busy_q <= 1'b1;
                                state  <= S_ITER;
                            end
                        end
`endif
                        default: begin
                            z_q    <= {{WIDTH{1'b0}}, alu_res};
                            ill_q  <= ~alu_ok;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.z        = z_q;
    assign bus.div_zero = dz_q;
    assign bus.illegal  = ill_q;

endmodule
